// File: rtl/enemy_pkg.sv
// Shared types and constants for the multi-enemy wave controller.
// The state encoding is visible on debug ports and fixed at 2 bits.
package enemy_pkg;

    typedef enum logic [1:0] {
        S_SPAWN_WAIT = 2'd0,
        S_UPDATE     = 2'd1,
        S_WAIT       = 2'd2,
        S_PICK       = 2'd3
    } enemy_state_t;

    // Fibonacci LFSR, taps 24,23,22,17 expressed as 0-based bit indices.
    localparam int LFSR_W     = 24;
    localparam int LFSR_TAP_A = 23;
    localparam int LFSR_TAP_B = 22;
    localparam int LFSR_TAP_C = 21;
    localparam int LFSR_TAP_D = 16;

    localparam int PICK_STRIDE = 3;
    localparam int PICK_SPAN   = 22;

    // The countdown needs headroom above the drawn range for INIT_DELAY+i.
    function automatic int delay_cnt_w(input int delay_w);
        return delay_w + 4;
    endfunction

    function automatic int health_bus_w(input int num_enemies, input int health_w);
        return num_enemies * health_w;
    endfunction

    function automatic int pick_offset(input int ch);
        return (PICK_STRIDE * ch) % PICK_SPAN;
    endfunction

endpackage

// File: rtl/enemy_channel_fsm.sv
// One enemy channel: lifecycle FSM, respawn countdown and health counter.
// kill_evt is the combinational 1->0 event; kill_pulse is its registered form.
module enemy_channel_fsm
    import enemy_pkg::*;
#(
    parameter int HEALTH_W   = 3,
    parameter int MAX_HEALTH = 2,
    parameter int DELAY_W    = 2,
    parameter int INIT_DELAY = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 tick,
    input  logic                 update_pulse,
    input  logic                 bottom_reached,
    input  logic                 hit_bullet,
    input  logic                 hit_player,
    input  logic [DELAY_W-1:0]   pick_bits,
    output logic                 in_reset,
    output logic                 update_en,
    output logic                 active,
    output logic [HEALTH_W-1:0]  health,
    output logic                 kill_evt,
    output logic                 kill_pulse,
    output logic [DELAY_W+3:0]   delay,
    output logic [1:0]           state_dbg
);

    localparam int DCW = delay_cnt_w(DELAY_W);

    enemy_state_t state;
    enemy_state_t state_nx;
    logic         hit_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_SPAWN_WAIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_SPAWN_WAIT: if (tick && (delay == '0)) state_nx = S_UPDATE;
            S_UPDATE: begin
                if (bottom_reached || hit_player || (health == '0)) state_nx = S_PICK;
                else                                                 state_nx = S_WAIT;
            end
            S_WAIT:       if (update_pulse) state_nx = S_UPDATE;
            S_PICK:       state_nx = S_SPAWN_WAIT;
            default:      state_nx = S_SPAWN_WAIT;
        endcase
    end

    always_comb begin
        in_reset  = (state == S_SPAWN_WAIT);
        update_en = (state == S_UPDATE);
        active    = (state == S_UPDATE) || (state == S_WAIT);
        hit_ok    = active && hit_bullet && (health != '0);
        kill_evt  = hit_ok && (health == HEALTH_W'(1));
        state_dbg = state;
    end

    // A zero delay still waits one tick, so delay d spans d+1 ticks.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            delay      <= DCW'(INIT_DELAY);
            health     <= HEALTH_W'(MAX_HEALTH);
            kill_pulse <= 1'b0;
        end else begin
            kill_pulse <= kill_evt;
            if ((state == S_SPAWN_WAIT) && tick) begin
                if (delay == '0) health <= HEALTH_W'(MAX_HEALTH);
                else             delay  <= delay - DCW'(1);
            end
            if (hit_ok) health <= health - HEALTH_W'(1);
            if (state == S_PICK) delay <= {{(DCW-DELAY_W){1'b0}}, pick_bits} + DCW'(1);
        end
    end

endmodule

// File: rtl/enemy_wave_ctrl.sv
// Multi-enemy lifecycle controller: shared tick prescaler, shared LFSR and kill
// counter around NUM_ENEMIES channel FSMs. resetn release is assumed clk-synchronous.
module enemy_wave_ctrl
    import enemy_pkg::*;
#(
    parameter int          NUM_ENEMIES = 4,
    parameter int          HEALTH_W    = 3,
    parameter int          MAX_HEALTH  = 2,
    parameter int          DELAY_W     = 2,
    parameter int          TICK_CYCLES = 25000000,
    parameter int          INIT_DELAY  = 1,
    parameter logic [23:0] LFSR_SEED   = 24'hACE1,
    parameter int          KILL_W      = 8
) (
    input  logic                                            clk,
    input  logic                                            resetn,
    input  logic                                            update_pulse,
    input  logic [NUM_ENEMIES-1:0]                          bottom_reached,
    input  logic [NUM_ENEMIES-1:0]                          hit_bullet,
    input  logic [NUM_ENEMIES-1:0]                          hit_player,
    output logic [NUM_ENEMIES-1:0]                          in_reset,
    output logic [NUM_ENEMIES-1:0]                          update_en,
    output logic [NUM_ENEMIES-1:0]                          active,
    output logic [health_bus_w(NUM_ENEMIES, HEALTH_W)-1:0]  health,
    output logic [NUM_ENEMIES-1:0]                          kill_pulse,
    output logic [KILL_W-1:0]                               kill_count,
    output logic [delay_cnt_w(DELAY_W)-1:0]                 delay0,
    output logic [2*NUM_ENEMIES-1:0]                        dbg_state
);

    localparam int PRE_W  = $clog2(TICK_CYCLES);
    localparam int DCW    = delay_cnt_w(DELAY_W);
    localparam int KSUM_W = KILL_W + 4;
    localparam logic [KSUM_W-1:0] KILL_SAT = KSUM_W'({KILL_W{1'b1}});

    logic [PRE_W-1:0]       prescale;
    logic                   tick;
    logic [LFSR_W-1:0]      lfsr;
    logic                   lfsr_fb;
    logic [NUM_ENEMIES-1:0] kill_evt;
    logic [KSUM_W-1:0]      kill_sum;
    logic [KILL_W-1:0]      kill_nx;

    assign tick = (prescale == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)   prescale <= PRE_W'(TICK_CYCLES - 1);
        else if (tick) prescale <= PRE_W'(TICK_CYCLES - 1);
        else           prescale <= prescale - PRE_W'(1);
    end

    // XNOR feedback: all-ones is the only lock-up state and is unreachable.
    assign lfsr_fb = ~(lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B] ^ lfsr[LFSR_TAP_C] ^ lfsr[LFSR_TAP_D]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr <= LFSR_SEED;
        else         lfsr <= {lfsr[LFSR_W-2:0], lfsr_fb};
    end

    always_comb begin
        kill_sum = KSUM_W'(kill_count);
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            kill_sum = kill_sum + KSUM_W'(kill_evt[i]);
        end
        kill_nx = (kill_sum > KILL_SAT) ? '1 : KILL_W'(kill_sum);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) kill_count <= '0;
        else         kill_count <= kill_nx;
    end

    for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_ch
        logic [DELAY_W-1:0] pick_bits;
        logic [DCW-1:0]     delay_ch;

        assign pick_bits = DELAY_W'({lfsr, lfsr} >> pick_offset(g));

        enemy_channel_fsm #(
            .HEALTH_W   (HEALTH_W),
            .MAX_HEALTH (MAX_HEALTH),
            .DELAY_W    (DELAY_W),
            .INIT_DELAY (INIT_DELAY + g)
        ) u_ch (
            .clk            (clk),
            .resetn         (resetn),
            .tick           (tick),
            .update_pulse   (update_pulse),
            .bottom_reached (bottom_reached[g]),
            .hit_bullet     (hit_bullet[g]),
            .hit_player     (hit_player[g]),
            .pick_bits      (pick_bits),
            .in_reset       (in_reset[g]),
            .update_en      (update_en[g]),
            .active         (active[g]),
            .health         (health[g*HEALTH_W +: HEALTH_W]),
            .kill_evt       (kill_evt[g]),
            .kill_pulse     (kill_pulse[g]),
            .delay          (delay_ch),
            .state_dbg      (dbg_state[2*g +: 2])
        );

        // Only channel 0's countdown is wired to the HEX display.
        if (g == 0) begin : g_show
            assign delay0 = delay_ch;
        end else begin : g_hide
            logic [DCW-1:0] unused_delay;
            assign unused_delay = delay_ch;
        end
    end

endmodule
